// File: rtl/im_loader.sv
// Loads num_words big-endian 32-bit words from a byte stream into instruction memory at BASE.., holding the CPU until done.
// Latency: one WRITE cycle per word after its 4th byte, then one DONE cycle; in_ready is low outside RECV, so the stream simply waits.
module im_loader #(
   parameter int ADDR_W = 8,
   parameter int BASE   = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [ADDR_W:0]   num_words,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   output logic              im_we,
   output logic [ADDR_W-1:0] im_addr,
   output logic [31:0]       im_wdata,
   output logic              cpu_hold,
   output logic              busy,
   output logic              done,
   output logic              err
);

   typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;

   localparam logic [ADDR_W+1:0] MAX_WORDS = (ADDR_W+2)'((1 << ADDR_W) - BASE);
   localparam logic [ADDR_W:0]   BASE_IDX  = (ADDR_W+1)'(BASE);

   state_t            state_q;
   logic [1:0]        bcnt_q;
   logic [ADDR_W:0]   rem_q;
   logic [ADDR_W:0]   widx_q;
   logic [31:0]       asm_q;
   logic              in_ready_q, im_we_q, cpu_hold_q, busy_q, done_q, err_q;
   logic [ADDR_W-1:0] im_addr_q;
   logic [31:0]       im_wdata_q;

   logic [31:0]       asm_d;
   logic              too_many;

   assign asm_d    = {asm_q[23:0], in_data};
   assign too_many = {1'b0, num_words} > MAX_WORDS;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         bcnt_q     <= '0;
         rem_q      <= '0;
         widx_q     <= BASE_IDX;
         asm_q      <= '0;
         in_ready_q <= 1'b0;
         im_we_q    <= 1'b0;
         im_addr_q  <= BASE_IDX[ADDR_W-1:0];
         im_wdata_q <= '0;
         cpu_hold_q <= 1'b1;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  if (num_words == '0) begin
                     err_q      <= 1'b0;
                     done_q     <= 1'b1;
                     cpu_hold_q <= 1'b0;
                     state_q    <= DONE;
                  end else if (too_many) begin
                     // Rejected request: cpu_hold deliberately left as it was.
                     err_q <= 1'b1;
                  end else begin
                     err_q      <= 1'b0;
                     rem_q      <= num_words;
                     bcnt_q     <= '0;
                     widx_q     <= BASE_IDX;
                     in_ready_q <= 1'b1;
                     busy_q     <= 1'b1;
                     cpu_hold_q <= 1'b1;
                     state_q    <= RECV;
                  end
               end
            end
            RECV: begin
               if (in_valid) begin
                  asm_q  <= asm_d;
                  bcnt_q <= bcnt_q + 2'd1;
                  if (bcnt_q == 2'd3) begin
                     in_ready_q <= 1'b0;
                     im_we_q    <= 1'b1;
                     im_addr_q  <= widx_q[ADDR_W-1:0];
                     im_wdata_q <= asm_d;
                     state_q    <= WRITE;
                  end
               end
            end
            WRITE: begin
               im_we_q <= 1'b0;
               widx_q  <= widx_q + 1'b1;
               rem_q   <= rem_q - 1'b1;
               bcnt_q  <= '0;
               if (rem_q == (ADDR_W+1)'(1)) begin
                  busy_q     <= 1'b0;
                  done_q     <= 1'b1;
                  cpu_hold_q <= 1'b0;
                  state_q    <= DONE;
               end else begin
                  in_ready_q <= 1'b1;
                  state_q    <= RECV;
               end
            end
            default: begin
               done_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign in_ready = in_ready_q;
   assign im_we    = im_we_q;
   assign im_addr  = im_addr_q;
   assign im_wdata = im_wdata_q;
   assign cpu_hold = cpu_hold_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign err      = err_q;

endmodule

// File: tb/tb_im_loader.sv
// Directed bench for im_loader (ADDR_W=8, BASE=0): table of full loads plus hand sequences for corner cases.
module tb_im_loader;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       start = 1'b0;
   logic [8:0] num_words = '0;
   logic       in_valid = 1'b0;
   logic [7:0] in_data = '0;
   logic       in_ready, im_we, cpu_hold, busy, done, err;
   logic [7:0] im_addr;
   logic [31:0] im_wdata;

   im_loader #(.ADDR_W(8), .BASE(0)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .num_words(num_words),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
      .cpu_hold(cpu_hold), .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   int total = 0;
   int passed = 0;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
   endtask

   // Write log captured from the memory port.
   logic [7:0]  wr_addr[$];
   logic [31:0] wr_data[$];

   always @(posedge clk) begin
      if (im_we) begin
         wr_addr.push_back(im_addr);
         wr_data.push_back(im_wdata);
         chk("in_ready_low_in_write", {63'd0, in_ready}, 64'd0);
         chk("busy_in_write", {63'd0, busy}, 64'd1);
      end
   end

   typedef struct packed {
      logic [8:0]       nw;
      logic [2:0][31:0] w;
      logic             gap;
      logic             restart;
   } vec_t;

   vec_t vecs[4];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start(input logic [8:0] n);
      start     = 1'b1;
      num_words = n;
      tick();
      start     = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      int n = 0;
      in_valid = 1'b1;
      in_data  = b;
      while (!in_ready && n < 100) begin
         tick();
         n++;
      end
      chk("byte_accept_ready", {63'd0, in_ready}, 64'd1);
      tick();
      in_valid = 1'b0;
   endtask

   task automatic run_load(input int v);
      int nw;
      nw = int'(vecs[v].nw);
      wr_addr.delete();
      wr_data.delete();
      pulse_start(vecs[v].nw);
      chk("start_busy", {63'd0, busy}, 64'd1);
      chk("start_hold", {63'd0, cpu_hold}, 64'd1);
      chk("start_err_clear", {63'd0, err}, 64'd0);
      for (int w = 0; w < nw; w++) begin
         for (int b = 0; b < 4; b++) begin
            send_byte(vecs[v].w[w][31-8*b -: 8]);
            if (w == 0 && b == 1 && vecs[v].gap) begin
               repeat (3) tick();
            end
            if (w == 0 && b == 1 && vecs[v].restart) begin
               pulse_start(9'd1);
               chk("restart_ignored_busy", {63'd0, busy}, 64'd1);
            end
         end
      end
      chk("last_write_we", {63'd0, im_we}, 64'd1);
      chk("last_write_hold", {63'd0, cpu_hold}, 64'd1);
      tick();
      chk("done_pulse", {63'd0, done}, 64'd1);
      chk("done_we_low", {63'd0, im_we}, 64'd0);
      chk("done_hold_low", {63'd0, cpu_hold}, 64'd0);
      chk("done_busy_low", {63'd0, busy}, 64'd0);
      tick();
      chk("done_one_cycle", {63'd0, done}, 64'd0);
      chk("hold_stays_low", {63'd0, cpu_hold}, 64'd0);
      chk("write_count", 64'(wr_addr.size()), 64'(nw));
      for (int i = 0; i < nw && i < wr_addr.size(); i++) begin
         chk($sformatf("wr_addr_v%0d_%0d", v, i), 64'(wr_addr[i]), 64'(i));
         chk($sformatf("wr_data_v%0d_%0d", v, i), 64'(wr_data[i]), 64'(vecs[v].w[i]));
      end
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_in_ready"}, {63'd0, in_ready}, 64'd0);
      chk({tag, "_im_we"},    {63'd0, im_we},    64'd0);
      chk({tag, "_im_addr"},  64'(im_addr),      64'd0);
      chk({tag, "_im_wdata"}, 64'(im_wdata),     64'd0);
      chk({tag, "_cpu_hold"}, {63'd0, cpu_hold}, 64'd1);
      chk({tag, "_busy"},     {63'd0, busy},     64'd0);
      chk({tag, "_done"},     {63'd0, done},     64'd0);
      chk({tag, "_err"},      {63'd0, err},      64'd0);
   endtask

   initial begin
      vecs[0] = '{nw: 9'd2, w: {32'h0, 32'h8C090004, 32'h20080005}, gap: 1'b0, restart: 1'b0};
      vecs[1] = '{nw: 9'd2, w: {32'h0, 32'h8C090004, 32'h20080005}, gap: 1'b1, restart: 1'b0};
      vecs[2] = '{nw: 9'd3, w: {32'h000000FF, 32'hA5A5A5A5, 32'h11223344}, gap: 1'b0, restart: 1'b0};
      vecs[3] = '{nw: 9'd2, w: {32'h0, 32'hDEADBEEF, 32'hCAFEF00D}, gap: 1'b0, restart: 1'b1};

      #3 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk_reset_vals("rst");
      rst_n = 1'b1;
      repeat (2) tick();
      chk("hold_after_reset", {63'd0, cpu_hold}, 64'd1);

      // Oversized request: 257 words cannot fit in 256 entries.
      wr_addr.delete();
      pulse_start(9'd257);
      chk("oversize_err", {63'd0, err}, 64'd1);
      chk("oversize_busy", {63'd0, busy}, 64'd0);
      chk("oversize_hold_kept", {63'd0, cpu_hold}, 64'd1);
      chk("oversize_in_ready", {63'd0, in_ready}, 64'd0);
      repeat (2) tick();
      chk("oversize_err_sticky", {63'd0, err}, 64'd1);
      chk("oversize_no_write", 64'(wr_addr.size()), 64'd0);

      for (int v = 0; v < 4; v++) run_load(v);

      // Zero-length load goes straight to DONE.
      wr_addr.delete();
      pulse_start(9'd0);
      chk("zero_done", {63'd0, done}, 64'd1);
      chk("zero_busy", {63'd0, busy}, 64'd0);
      tick();
      chk("zero_done_end", {63'd0, done}, 64'd0);
      chk("zero_busy_after", {63'd0, busy}, 64'd0);
      chk("zero_no_write", 64'(wr_addr.size()), 64'd0);

      // Reset after word 0 plus two bytes of word 1 of a three-word load.
      wr_addr.delete();
      wr_data.delete();
      pulse_start(9'd3);
      for (int b = 0; b < 4; b++) send_byte(vecs[2].w[0][31-8*b -: 8]);
      send_byte(8'hA5);
      send_byte(8'hA5);
      rst_n = 1'b0;
      #1;
      chk_reset_vals("midrst");
      repeat (2) tick();
      rst_n = 1'b1;
      tick();
      chk("midrst_write_count", 64'(wr_addr.size()), 64'd1);
      if (wr_addr.size() > 0)
         chk("midrst_word0", 64'(wr_data[0]), 64'h11223344);
      chk("midrst_hold", {63'd0, cpu_hold}, 64'd1);
      run_load(0);

      // Largest legal length is accepted.
      pulse_start(9'd256);
      chk("max_len_busy", {63'd0, busy}, 64'd1);
      chk("max_len_err", {63'd0, err}, 64'd0);
      chk("max_len_ready", {63'd0, in_ready}, 64'd1);
      rst_n = 1'b0;
      #1;
      chk("max_len_abort_busy", {63'd0, busy}, 64'd0);
      tick();
      rst_n = 1'b1;
      tick();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
